hero_collision: RTL

- Upstream companion to the hero movement controller. It produces the 4-bit `collision` vector that the controller uses to veto single-pixel moves.
- On each `start` pulse it snapshots the hero position, then scans a block-position table through a synchronous-read port. For each direction it tests whether the hero square, shifted one pixel that way, would overlap any block square.
- Results are latched and held until the next scan completes.

---
 rtl/hero_collision_pkg.sv | 20 ++
 rtl/hero_collision_rect_overlap_dir.sv | 37 +++
 rtl/hero_collision.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hero_collision_pkg.sv
// Constants shared between the hero collision scanner and the movement controller.
package hero_collision_pkg;

  // Bit positions inside the 4-bit collision / move vector.
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_LEFT  = 0;

  localparam int HERO_SIDE  = 60;
  localparam int BLOCK_SIDE = 60;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/hero_collision_rect_overlap_dir.sv
// For one hero/block pair, flags each direction in which a one-pixel hero move
// would make the two squares overlap.
module rect_overlap_dir #(
  parameter int HERO_SIDE  = 60,
  parameter int BLOCK_SIDE = 60
) (
  input  logic [11:0] hero_x,
  input  logic [11:0] hero_y,
  input  logic [11:0] blk_x,
  input  logic [11:0] blk_y,
  output logic [3:0]  dir_hit
);
  import hero_collision_pkg::*;

  localparam logic [12:0] H   = 13'(HERO_SIDE);
  localparam logic [12:0] B   = 13'(BLOCK_SIDE);
  localparam logic [12:0] ONE = 13'd1;

  logic [12:0] hx, hy, bx, by;
  logic        x_ov, y_ov;

  // One extra bit keeps every sum exact; the -1 moves are folded onto the
  // opposite side of each inequality so nothing is ever subtracted.
  assign hx = {1'b0, hero_x};
  assign hy = {1'b0, hero_y};
  assign bx = {1'b0, blk_x};
  assign by = {1'b0, blk_y};

  assign x_ov = (hx < bx + B) && (bx < hx + H);
  assign y_ov = (hy < by + B) && (by < hy + H);

  assign dir_hit[DIR_UP]    = x_ov && (hy < by + B + ONE) && (by + ONE < hy + H);
  assign dir_hit[DIR_DOWN]  = x_ov && (hy + ONE < by + B) && (by < hy + ONE + H);
  assign dir_hit[DIR_LEFT]  = y_ov && (hx < bx + B + ONE) && (bx + ONE < hx + H);
  assign dir_hit[DIR_RIGHT] = y_ov && (hx + ONE < bx + B) && (bx < hx + ONE + H);

endmodule

// File: rtl/hero_collision.sv
// Scans the block table through a synchronous-read port and latches which
// single-pixel hero moves would collide with any block.
module hero_collision #(
  parameter int NUM_BLOCKS = 16,
  parameter int ADDR_W     = 4,
  parameter int HERO_SIDE  = hero_collision_pkg::HERO_SIDE,
  parameter int BLOCK_SIDE = hero_collision_pkg::BLOCK_SIDE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       hero_x,
  input  logic [11:0]       hero_y,
  output logic [ADDR_W-1:0] blk_addr,
  input  logic [11:0]       blk_x,
  input  logic [11:0]       blk_y,
  output logic              busy,
  output logic              valid,
  output logic [3:0]        collision
);
  import hero_collision_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLOCKS - 1);

  scan_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              rd_pending_reg, rd_pending_next;
  logic              busy_reg, busy_next;
  logic              valid_reg, valid_next;
  logic [3:0]        coll_reg, coll_next;
  logic [3:0]        acc_reg, acc_next;
  logic [11:0]       hx_reg, hx_next;
  logic [11:0]       hy_reg, hy_next;
  logic [3:0]        dir_hit;
  logic              slot_used;

  rect_overlap_dir #(
    .HERO_SIDE (HERO_SIDE),
    .BLOCK_SIDE(BLOCK_SIDE)
  ) u_overlap (
    .hero_x (hx_reg),
    .hero_y (hy_reg),
    .blk_x  (blk_x),
    .blk_y  (blk_y),
    .dir_hit(dir_hit)
  );

  // A (0,0) entry marks an unused table slot.
  assign slot_used = (blk_x != 12'd0) || (blk_y != 12'd0);

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    rd_pending_next = 1'b0;
    busy_next       = busy_reg;
    valid_next      = 1'b0;
    coll_next       = coll_reg;
    acc_next        = acc_reg;
    hx_next         = hx_reg;
    hy_next         = hy_reg;

    if (rd_pending_reg && slot_used) begin
      acc_next = acc_reg | dir_hit;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          hx_next    = hero_x;
          hy_next    = hero_y;
          acc_next   = 4'd0;
          addr_next  = '0;
          busy_next  = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        rd_pending_next = 1'b1;
        if (addr_reg == LAST_ADDR) begin
          state_next = DRAIN;
        end else begin
          addr_next = addr_reg + 1'b1;
        end
      end
      DRAIN: begin
        state_next = DONE;
      end
      DONE: begin
        coll_next  = acc_reg;
        valid_next = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      rd_pending_reg <= 1'b0;
      busy_reg       <= 1'b0;
      valid_reg      <= 1'b0;
      coll_reg       <= 4'd0;
      acc_reg        <= 4'd0;
      hx_reg         <= 12'd0;
      hy_reg         <= 12'd0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      rd_pending_reg <= rd_pending_next;
      busy_reg       <= busy_next;
      valid_reg      <= valid_next;
      coll_reg       <= coll_next;
      acc_reg        <= acc_next;
      hx_reg         <= hx_next;
      hy_reg         <= hy_next;
    end
  end

  assign blk_addr  = addr_reg;
  assign busy      = busy_reg;
  assign valid     = valid_reg;
  assign collision = coll_reg;

endmodule
